stream_in: RTL and testbench

STREAM_IN -- requirements
Module: stream_in

---
 rtl/stream_in.sv | 91 +++++++++
 tb/tb_stream_in.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/stream_in.sv
// Collects TOTAL_ELEM serial elements into one bus vector; bus_valid_o rises one cycle after the last element.
// Upstream cannot be stalled: one full vector is buffered while the output waits, further input is dropped and flagged.
module stream_in #(
    parameter int DATA_WIDTH = 16,
    parameter int TOTAL_ELEM = 10,
    parameter int CNT_WIDTH  = $clog2(TOTAL_ELEM + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [DATA_WIDTH-1:0]                  stream_data_i,
    input  logic                                   stream_valid_i,
    input  logic                                   stream_clr_i,
    output logic [TOTAL_ELEM-1:0][DATA_WIDTH-1:0]  bus_data_o,
    output logic                                   bus_valid_o,
    input  logic                                   bus_ready_i,
    output logic [CNT_WIDTH-1:0]                   elem_count_o,
    output logic                                   overflow_o
);

    localparam int IDX_W = $clog2(TOTAL_ELEM);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TOTAL_ELEM - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(TOTAL_ELEM);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                                state_q;
    logic [TOTAL_ELEM-1:0][DATA_WIDTH-1:0] fill_q;
    logic [TOTAL_ELEM-1:0][DATA_WIDTH-1:0] load_vec;
    logic [IDX_W-1:0]                      wr_idx;
    logic                                  slot_free;

    assign slot_free = !bus_valid_o || bus_ready_i;
    assign wr_idx    = elem_count_o[IDX_W-1:0];

    // Completing element bypasses the fill buffer straight into the last lane.
    always_comb begin
        load_vec                 = fill_q;
        load_vec[TOTAL_ELEM-1]   = stream_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || stream_clr_i) begin
            state_q      <= FILL;
            elem_count_o <= '0;
            bus_valid_o  <= 1'b0;
            bus_data_o   <= '0;
            overflow_o   <= 1'b0;
        end else begin
            if (bus_valid_o && bus_ready_i) begin
                bus_valid_o <= 1'b0;
            end
            case (state_q)
                FILL: begin
                    if (stream_valid_i) begin
                        if (elem_count_o == LAST_CNT) begin
                            if (slot_free) begin
                                bus_data_o   <= load_vec;
                                bus_valid_o  <= 1'b1;
                                elem_count_o <= '0;
                            end else begin
                                fill_q[wr_idx] <= stream_data_i;
                                elem_count_o   <= FULL_CNT;
                                state_q        <= HOLD;
                            end
                        end else begin
                            fill_q[wr_idx] <= stream_data_i;
                            elem_count_o   <= elem_count_o + CNT_WIDTH'(1);
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        bus_data_o  <= fill_q;
                        bus_valid_o <= 1'b1;
                        state_q     <= FILL;
                        if (stream_valid_i) begin
                            fill_q[0]    <= stream_data_i;
                            elem_count_o <= CNT_WIDTH'(1);
                        end else begin
                            elem_count_o <= '0;
                        end
                    end else if (stream_valid_i) begin
                        overflow_o <= 1'b1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_in.sv
module tb_stream_in;

    localparam int DW = 16;
    localparam int N  = 4;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] stream_data_i = '0;
    logic          stream_valid_i = 1'b0;
    logic          stream_clr_i = 1'b0;
    vec_t          bus_data_o;
    logic          bus_valid_o;
    logic          bus_ready_i = 1'b0;
    logic [2:0]    elem_count_o;
    logic          overflow_o;

    stream_in #(.DATA_WIDTH(DW), .TOTAL_ELEM(N)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stream_data_i  (stream_data_i),
        .stream_valid_i (stream_valid_i),
        .stream_clr_i   (stream_clr_i),
        .bus_data_o     (bus_data_o),
        .bus_valid_o    (bus_valid_o),
        .bus_ready_i    (bus_ready_i),
        .elem_count_o   (elem_count_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;

    // Reference: collected elements as a queue, output slot as a plain value.
    logic [DW-1:0] m_buf[$];
    bit            m_vld = 0;
    vec_t          m_dat = '0;
    bit            m_ovf = 0;
    vec_t          sb[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(bit r, bit c, bit v, logic [DW-1:0] d, bit rdy);
        bit   free;
        bit   emit;
        vec_t ev;
        free = !m_vld || rdy;
        emit = 0;
        ev   = '0;
        if (r || c) begin
            m_buf.delete();
            m_vld = 0;
            m_dat = '0;
            m_ovf = 0;
            sb.delete();
        end else begin
            if (m_buf.size() == N) begin
                if (free) begin
                    emit = 1;
                    for (int i = 0; i < N; i++) ev[i] = m_buf[i];
                    m_buf.delete();
                    if (v) m_buf.push_back(d);
                end else if (v) begin
                    m_ovf = 1;
                end
            end else if (v) begin
                m_buf.push_back(d);
                if (m_buf.size() == N && free) begin
                    emit = 1;
                    for (int i = 0; i < N; i++) ev[i] = m_buf[i];
                    m_buf.delete();
                end
            end
            if (emit) begin
                m_vld = 1;
                m_dat = ev;
                sb.push_back(ev);
            end else if (m_vld && rdy) begin
                m_vld = 0;
            end
        end
    endtask

    task automatic cyc(bit r, bit c, bit v, logic [DW-1:0] d, bit rdy);
        rst_i = r; stream_clr_i = c; stream_valid_i = v;
        stream_data_i = d; bus_ready_i = rdy;
        @(posedge clk_i);
        model_step(r, c, v, d, rdy);
        #1;
    endtask

    task automatic send_seq(bit rdy, int first, int cnt);
        for (int i = 0; i < cnt; i++) cyc(0, 0, 1, DW'(first + i), rdy);
    endtask

    // Monitor: per-cycle state against the model, vectors against the scoreboard on transfer.
    initial begin
        vec_t exp_v;
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                chk("bus_valid", {63'd0, bus_valid_o}, {63'd0, m_vld});
                chk("elem_count", {61'd0, elem_count_o}, 64'(m_buf.size()));
                chk("overflow", {63'd0, overflow_o}, {63'd0, m_ovf});
                chk("bus_data", bus_data_o, m_dat);
                if (!rst_i && !stream_clr_i && bus_valid_o && bus_ready_i) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_unexpected: got vector %h expected none", bus_data_o);
                    end else begin
                        exp_v = sb.pop_front();
                        chk("sb_vector", bus_data_o, exp_v);
                    end
                end
            end
        end
    end

    initial begin
        cyc(1, 0, 0, '0, 0);
        mon_en = 1;
        cyc(1, 0, 0, '0, 0);
        chk("rst_valid", {63'd0, bus_valid_o}, 64'd0);
        chk("rst_data", bus_data_o, 64'd0);

        // Back-to-back with ready high
        send_seq(1, 1, 4);
        chk("b2b_vec", bus_data_o, {16'd4, 16'd3, 16'd2, 16'd1});
        cyc(0, 0, 0, '0, 1);

        // Gapped input
        cyc(0, 0, 1, 16'hA, 1);
        cyc(0, 0, 0, '0, 1);
        cyc(0, 0, 0, '0, 1);
        cyc(0, 0, 1, 16'hB, 1);
        cyc(0, 0, 1, 16'hC, 1);
        cyc(0, 0, 0, '0, 1);
        cyc(0, 0, 1, 16'hD, 1);
        chk("gap_vec", bus_data_o, {16'hD, 16'hC, 16'hB, 16'hA});
        cyc(0, 0, 0, '0, 1);

        // Backpressure and overflow
        send_seq(0, 1, 4);
        send_seq(0, 5, 4);
        chk("hold_count", {61'd0, elem_count_o}, 64'd4);
        cyc(0, 0, 1, 16'd9, 0);
        chk("ovf_set", {63'd0, overflow_o}, 64'd1);
        cyc(0, 0, 0, '0, 1);
        chk("bp_vec2", bus_data_o, {16'd8, 16'd7, 16'd6, 16'd5});
        chk("ovf_sticky", {63'd0, overflow_o}, 64'd1);

        // HOLD release with concurrent input
        send_seq(0, 9, 4);
        cyc(0, 0, 1, 16'hE, 1);
        chk("rel_count", {61'd0, elem_count_o}, 64'd1);
        chk("rel_vec", bus_data_o, {16'd12, 16'd11, 16'd10, 16'd9});
        cyc(0, 1, 0, '0, 1);

        // Clear, then reset, mid-vector
        for (int k = 0; k < 2; k++) begin
            send_seq(1, 1, 2);
            cyc(k == 1, k == 0, 1, 16'hF, 1);
            chk("clr_count", {61'd0, elem_count_o}, 64'd0);
            send_seq(1, 5, 4);
            chk("clr_vec", bus_data_o, {16'd8, 16'd7, 16'd6, 16'd5});
            cyc(0, 0, 0, '0, 1);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
                $urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 1) == 1);
        end

        // Drain: every emitted vector must have been consumed
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0, 1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
